interrupt_sequencer: RTL and testbench



---
 rtl/interrupt_sequencer.sv | 197 +++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// Producer-side controller for the decode/execute buffer. When an external
// interrupt rises, it drains the in-flight instructions, then injects two
// PUSH micro-ops that save the 32-bit return PC on the stack (high half first,
// then low half). Finally it redirects fetch to the interrupt vector. Its
// injected control/data are muxed over the normal decoder outputs by the
// parent using inject_valid.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   asynchronous reset, active-high
//   interrupt      in   external interrupt request (rising edge triggers)
//   stall          in   hazard-unit stall; freezes sequencer progress
//   branch_taken   in   execute stage redirects the PC this cycle
//   branch_target  in   redirect target, valid with branch_taken
//   pc_decode      in   PC of the instruction currently in decode
//   inject_valid   out  select inject_ctrl/inject_data at the D/E input
//   inject_ctrl    out  control bundle to inject (PUSH)
//   inject_data    out  value to push (drives readData1)
//   interrupt_out  out  drives the D/E buffer interrupt input
//   flush_fd       out  flush of the F/D buffer
//   hold_pc        out  freeze the fetch PC
//   pc_load        out  load pc_load_value into the PC
//   pc_load_value  out  new PC (always the interrupt vector)
//   busy           out  sequencer not idle
// -----------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter int                CTRL_W       = 14,
  parameter int                PC_W         = 32,
  parameter int                DATA_W       = 16,
  parameter int                DRAIN_CYCLES = 2,
  parameter logic [CTRL_W-1:0] PUSH_CTRL    = 14'h0000,
  parameter logic [PC_W-1:0]   VECTOR_ADDR  = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              interrupt,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [PC_W-1:0]   branch_target,
  input  logic [PC_W-1:0]   pc_decode,
  output logic              inject_valid,
  output logic [CTRL_W-1:0] inject_ctrl,
  output logic [DATA_W-1:0] inject_data,
  output logic              interrupt_out,
  output logic              flush_fd,
  output logic              hold_pc,
  output logic              pc_load,
  output logic [PC_W-1:0]   pc_load_value,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAIN,
    S_PUSH_HI,
    S_PUSH_LO,
    S_VECTOR
  } state_t;

  state_t            state_q, state_d;
  logic              pending_q, pending_d;
  logic              irq_q, irq_d;
  logic [PC_W-1:0]   ret_pc_q, ret_pc_d;
  logic [2:0]        cnt_q, cnt_d;

  logic              inject_valid_q, inject_valid_d;
  logic [CTRL_W-1:0] inject_ctrl_q, inject_ctrl_d;
  logic [DATA_W-1:0] inject_data_q, inject_data_d;
  logic              interrupt_out_q, interrupt_out_d;
  logic              flush_fd_q, flush_fd_d;
  logic              hold_pc_q, hold_pc_d;
  logic              pc_load_q, pc_load_d;
  logic              busy_q, busy_d;

  logic              rise;

  assign rise = interrupt & ~irq_q;

  // Next-state logic. The pending flag is a single-entry request queue: a
  // request is consumed when service starts, so an edge arriving during
  // service is remembered and serviced once the sequencer is back in IDLE,
  // while any further edges before that point are dropped.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | rise;
    irq_d     = interrupt;
    ret_pc_d  = ret_pc_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if ((pending_q | rise) && !stall) begin
          ret_pc_d  = pc_decode;
          cnt_d     = 3'(DRAIN_CYCLES);
          pending_d = 1'b0;
          state_d   = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // A redirect resolving while we drain is the true return address.
        if (branch_taken) begin
          ret_pc_d = branch_target;
        end
        if (!stall) begin
          cnt_d = cnt_q - 3'd1;
          if (cnt_q == 3'd1) begin
            state_d = S_PUSH_HI;
          end
        end
      end
      S_PUSH_HI: begin
        if (!stall) begin
          state_d = S_PUSH_LO;
        end
      end
      S_PUSH_LO: begin
        if (!stall) begin
          state_d = S_VECTOR;
        end
      end
      S_VECTOR: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Moore outputs decoded from the upcoming state so they can be registered
  // and still line up with the state they belong to. ret_pc only changes in
  // IDLE/DRAIN, so the pushed halves are stable throughout the push states.
  always_comb begin
    inject_valid_d  = (state_d == S_PUSH_HI) || (state_d == S_PUSH_LO);
    inject_ctrl_d   = inject_valid_d ? PUSH_CTRL : '0;
    inject_data_d   = '0;
    if (state_d == S_PUSH_HI) begin
      inject_data_d = ret_pc_d[PC_W-1:DATA_W];
    end else if (state_d == S_PUSH_LO) begin
      inject_data_d = ret_pc_d[DATA_W-1:0];
    end
    interrupt_out_d = inject_valid_d;
    flush_fd_d      = (state_d == S_DRAIN) || (state_d == S_VECTOR);
    hold_pc_d       = (state_d == S_DRAIN) || inject_valid_d;
    pc_load_d       = (state_d == S_VECTOR);
    busy_d          = (state_d != S_IDLE);
  end

  // All state and registered outputs; reset aborts any sequence in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      pending_q       <= 1'b0;
      irq_q           <= 1'b0;
      ret_pc_q        <= '0;
      cnt_q           <= '0;
      inject_valid_q  <= 1'b0;
      inject_ctrl_q   <= '0;
      inject_data_q   <= '0;
      interrupt_out_q <= 1'b0;
      flush_fd_q      <= 1'b0;
      hold_pc_q       <= 1'b0;
      pc_load_q       <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      irq_q           <= irq_d;
      ret_pc_q        <= ret_pc_d;
      cnt_q           <= cnt_d;
      inject_valid_q  <= inject_valid_d;
      inject_ctrl_q   <= inject_ctrl_d;
      inject_data_q   <= inject_data_d;
      interrupt_out_q <= interrupt_out_d;
      flush_fd_q      <= flush_fd_d;
      hold_pc_q       <= hold_pc_d;
      pc_load_q       <= pc_load_d;
      busy_q          <= busy_d;
    end
  end

  assign inject_valid  = inject_valid_q;
  assign inject_ctrl   = inject_ctrl_q;
  assign inject_data   = inject_data_q;
  assign interrupt_out = interrupt_out_q;
  assign flush_fd      = flush_fd_q;
  assign hold_pc       = hold_pc_q;
  assign pc_load       = pc_load_q;
  assign busy          = busy_q;

  // The load target never changes, so it is simply tied to the vector.
  assign pc_load_value = VECTOR_ADDR;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
//
// Self-checking bench for interrupt_sequencer. A behavioural model tracks the
// service sequence as a position in the script drain -> push high -> push low
// -> vector, plus a one-entry request queue, and predicts every output after
// each clock edge. Scenario tasks add fixed expectations for the key cases.
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;

  localparam int          CTRL_W       = 14;
  localparam int          PC_W         = 32;
  localparam int          DATA_W       = 16;
  localparam int          DRAIN_CYCLES = 2;
  localparam logic [13:0] PUSH_CTRL    = 14'h25A3;
  localparam logic [31:0] VECTOR_ADDR  = 32'h0000_0140;

  localparam int P_IDLE   = 0;
  localparam int P_DRAIN  = 1;
  localparam int P_HI     = 2;
  localparam int P_LO     = 3;
  localparam int P_VECTOR = 4;

  logic              clk;
  logic              rst;
  logic              interrupt;
  logic              stall;
  logic              branch_taken;
  logic [PC_W-1:0]   branch_target;
  logic [PC_W-1:0]   pc_decode;
  logic              inject_valid;
  logic [CTRL_W-1:0] inject_ctrl;
  logic [DATA_W-1:0] inject_data;
  logic              interrupt_out;
  logic              flush_fd;
  logic              hold_pc;
  logic              pc_load;
  logic [PC_W-1:0]   pc_load_value;
  logic              busy;

  int checks = 0;
  int errors = 0;

  // Model state: where we are in the service script, drain cycles left,
  // captured return PC, queued request and previous interrupt level.
  int          m_phase;
  int          m_left;
  logic [31:0] m_ret;
  bit          m_queued;
  bit          m_prev;

  interrupt_sequencer #(
    .CTRL_W(CTRL_W),
    .PC_W(PC_W),
    .DATA_W(DATA_W),
    .DRAIN_CYCLES(DRAIN_CYCLES),
    .PUSH_CTRL(PUSH_CTRL),
    .VECTOR_ADDR(VECTOR_ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .interrupt(interrupt),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .pc_decode(pc_decode),
    .inject_valid(inject_valid),
    .inject_ctrl(inject_ctrl),
    .inject_data(inject_data),
    .interrupt_out(interrupt_out),
    .flush_fd(flush_fd),
    .hold_pc(hold_pc),
    .pc_load(pc_load),
    .pc_load_value(pc_load_value),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [67:0] dut_bundle();
    return {busy, inject_valid, inject_ctrl, inject_data, interrupt_out,
            flush_fd, hold_pc, pc_load, pc_load_value};
  endfunction

  function automatic logic [67:0] model_bundle();
    logic        iv;
    logic [15:0] d;
    iv = (m_phase == P_HI) || (m_phase == P_LO);
    d  = 16'h0000;
    if (m_phase == P_HI) d = m_ret[31:16];
    if (m_phase == P_LO) d = m_ret[15:0];
    return {(m_phase != P_IDLE), iv, (iv ? PUSH_CTRL : 14'h0000), d, iv,
            (m_phase == P_DRAIN || m_phase == P_VECTOR),
            (m_phase == P_DRAIN || iv), (m_phase == P_VECTOR), VECTOR_ADDR};
  endfunction

  task automatic model_reset();
    m_phase  = P_IDLE;
    m_left   = 0;
    m_ret    = 32'h0;
    m_queued = 1'b0;
    m_prev   = 1'b0;
  endtask

  // Advance the model by one clock using the inputs presented for that edge.
  task automatic model_step();
    bit rise;
    rise = interrupt && !m_prev;
    if (m_phase == P_IDLE) begin
      if ((m_queued || rise) && !stall) begin
        m_ret    = pc_decode;
        m_left   = DRAIN_CYCLES;
        m_phase  = P_DRAIN;
        m_queued = 1'b0;
      end else if (rise) begin
        m_queued = 1'b1;
      end
    end else begin
      if (rise) m_queued = 1'b1;
      case (m_phase)
        P_DRAIN: begin
          if (branch_taken) m_ret = branch_target;
          if (!stall) begin
            if (m_left == 1) m_phase = P_HI;
            m_left = m_left - 1;
          end
        end
        P_HI:     if (!stall) m_phase = P_LO;
        P_LO:     if (!stall) m_phase = P_VECTOR;
        default:  m_phase = P_IDLE;
      endcase
    end
    m_prev = interrupt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle_idle();
    interrupt    = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    interrupt     = 1'b0;
    stall         = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    pc_decode     = 32'h0;
    model_reset();
    #7;
    checks++;
    if (dut_bundle() !== {36'h0, VECTOR_ADDR}) begin
      errors++;
      $display("[TB] FAIL reset_outputs got %h expected %h", dut_bundle(), {36'h0, VECTOR_ADDR});
    end
    #5;
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_idle busy got %b expected 0", busy);
    end
  endtask

  task automatic test_single();
    logic [15:0] pushes[$];
    int          pl = 0;
    int          first_idle = 0;
    settle_idle();
    pc_decode = 32'h0001_2345;
    interrupt = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 2) interrupt = 1'b0;
      checks++;
      if (dut_bundle() !== model_bundle()) begin
        errors++;
        $display("[TB] FAIL single_cycle%0d got %h expected %h", k, dut_bundle(), model_bundle());
      end
      if (inject_valid) pushes.push_back(inject_data);
      if (pc_load) pl++;
      if (!busy && first_idle == 0) first_idle = k;
    end
    checks++;
    if (pushes.size() != 2) begin
      errors++;
      $display("[TB] FAIL single_push_count got %0d expected 2", pushes.size());
    end else begin
      checks++;
      if (pushes[0] !== 16'h0001 || pushes[1] !== 16'h2345) begin
        errors++;
        $display("[TB] FAIL single_push_order got %h,%h expected 0001,2345", pushes[0], pushes[1]);
      end
    end
    checks++;
    if (pl != 1) begin
      errors++;
      $display("[TB] FAIL single_pc_load_count got %0d expected 1", pl);
    end
    checks++;
    if (first_idle != 6) begin
      errors++;
      $display("[TB] FAIL single_latency got %0d expected 6", first_idle);
    end
  endtask

  task automatic test_stall_push();
    int hi = 0;
    int lo = 0;
    int last_hi = 0;
    int first_lo = 0;
    settle_idle();
    pc_decode = 32'h0001_2345;
    interrupt = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 2) interrupt = 1'b0;
      if (k == 3) stall = 1'b1;
      if (k == 6) stall = 1'b0;
      checks++;
      if (dut_bundle() !== model_bundle()) begin
        errors++;
        $display("[TB] FAIL stall_cycle%0d got %h expected %h", k, dut_bundle(), model_bundle());
      end
      if (inject_valid && inject_data == 16'h0001) begin
        hi++;
        last_hi = k;
      end
      if (inject_valid && inject_data == 16'h2345) begin
        lo++;
        if (first_lo == 0) first_lo = k;
      end
    end
    checks++;
    if (hi != 4) begin
      errors++;
      $display("[TB] FAIL stall_hi_hold got %0d expected 4", hi);
    end
    checks++;
    if (lo != 1) begin
      errors++;
      $display("[TB] FAIL stall_lo_count got %0d expected 1", lo);
    end
    checks++;
    if (first_lo != last_hi + 1) begin
      errors++;
      $display("[TB] FAIL stall_order got lo at %0d expected %0d", first_lo, last_hi + 1);
    end
  endtask

  task automatic test_branch();
    logic [15:0] pushes[$];
    settle_idle();
    pc_decode = $urandom;
    interrupt = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      branch_taken = 1'b0;
      if (k == 1) begin
        branch_taken  = 1'b1;
        branch_target = 32'h0000_0ABC;
      end
      if (k == 2) interrupt = 1'b0;
      if (k == 3) begin
        branch_taken  = 1'b1;
        branch_target = 32'hFFFF_FFFF;
      end
      checks++;
      if (dut_bundle() !== model_bundle()) begin
        errors++;
        $display("[TB] FAIL branch_cycle%0d got %h expected %h", k, dut_bundle(), model_bundle());
      end
      if (inject_valid) pushes.push_back(inject_data);
    end
    checks++;
    if (pushes.size() != 2) begin
      errors++;
      $display("[TB] FAIL branch_push_count got %0d expected 2", pushes.size());
    end else begin
      checks++;
      if (pushes[0] !== 16'h0000 || pushes[1] !== 16'h0ABC) begin
        errors++;
        $display("[TB] FAIL branch_push_order got %h,%h expected 0000,0abc", pushes[0], pushes[1]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pushes[$];
    int          pl = 0;
    logic        busy6 = 1'b0;
    logic        busy7 = 1'b0;
    settle_idle();
    pc_decode = 32'h1111_2222;
    interrupt = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 2) interrupt = 1'b0;
      if (k == 4) interrupt = 1'b1;
      if (k == 5) begin
        interrupt = 1'b0;
        pc_decode = 32'h3333_4444;
      end
      if (k == 6) interrupt = 1'b1;
      if (k == 7) interrupt = 1'b0;
      checks++;
      if (dut_bundle() !== model_bundle()) begin
        errors++;
        $display("[TB] FAIL b2b_cycle%0d got %h expected %h", k, dut_bundle(), model_bundle());
      end
      if (inject_valid) pushes.push_back(inject_data);
      if (pc_load) pl++;
      if (k == 6) busy6 = busy;
      if (k == 7) busy7 = busy;
    end
    checks++;
    if (busy6 !== 1'b0 || busy7 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_restart got busy %b%b expected 01", busy6, busy7);
    end
    checks++;
    if (pl != 2) begin
      errors++;
      $display("[TB] FAIL b2b_sequences got %0d expected 2", pl);
    end
    checks++;
    if (pushes.size() != 4) begin
      errors++;
      $display("[TB] FAIL b2b_push_count got %0d expected 4", pushes.size());
    end else begin
      checks++;
      if (pushes[0] !== 16'h1111 || pushes[1] !== 16'h2222 ||
          pushes[2] !== 16'h3333 || pushes[3] !== 16'h4444) begin
        errors++;
        $display("[TB] FAIL b2b_push_order got %h,%h,%h,%h expected 1111,2222,3333,4444",
                 pushes[0], pushes[1], pushes[2], pushes[3]);
      end
    end
  endtask

  task automatic test_async_reset();
    int pushes_after = 0;
    settle_idle();
    pc_decode = 32'hDEAD_BEEF;
    interrupt = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      if (k == 2) interrupt = 1'b0;
    end
    checks++;
    if (inject_valid !== 1'b1 || inject_data !== 16'hDEAD) begin
      errors++;
      $display("[TB] FAIL rst_pre_push got %b/%h expected 1/dead", inject_valid, inject_data);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (dut_bundle() !== {36'h0, VECTOR_ADDR}) begin
      errors++;
      $display("[TB] FAIL rst_async got %h expected %h", dut_bundle(), {36'h0, VECTOR_ADDR});
    end
    tick();
    model_reset();
    tick();
    model_reset();
    #2;
    rst = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      checks++;
      if (dut_bundle() !== model_bundle()) begin
        errors++;
        $display("[TB] FAIL rst_after_cycle%0d got %h expected %h", k, dut_bundle(), model_bundle());
      end
      if (inject_valid || busy) pushes_after++;
    end
    checks++;
    if (pushes_after != 0) begin
      errors++;
      $display("[TB] FAIL rst_no_resume got %0d active cycles expected 0", pushes_after);
    end
  endtask

  task automatic test_random();
    settle_idle();
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 5) == 0) interrupt = ~interrupt;
      stall         = ($urandom_range(0, 3) == 0);
      branch_taken  = ($urandom_range(0, 2) == 0);
      branch_target = $urandom;
      pc_decode     = $urandom;
      tick();
      checks++;
      if (dut_bundle() !== model_bundle()) begin
        errors++;
        $display("[TB] FAIL random_cycle%0d got %h expected %h", k, dut_bundle(), model_bundle());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stall_push();
    test_branch();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
